// File: rtl/ysyx_22041207_axi_read_arbiter.sv
// N-master to 1-slave AXI read arbiter: IDLE/ADDR/DATA FSM, one transaction owns the slave, 1-cycle arbitration.
// Fixed priority (lowest index wins) by default; define YSYX_22041207_ARB_RR_EN for round-robin arbitration.
module ysyx_22041207_axi_read_arbiter #(
    parameter  int NUM_MASTERS   = 2,
    parameter  int RW_DATA_WIDTH = 64,
    parameter  int RW_ADDR_WIDTH = 64,
    parameter  int SIZE_WIDTH    = 8,
    localparam int IDX_W         = $clog2(NUM_MASTERS)
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [NUM_MASTERS-1:0]                 m_r_valid_i,
    output logic [NUM_MASTERS-1:0]                 m_r_ready_o,
    input  logic [NUM_MASTERS*RW_ADDR_WIDTH-1:0]   m_r_addr_i,
    input  logic [NUM_MASTERS*SIZE_WIDTH-1:0]      m_r_size_i,
    output logic [NUM_MASTERS-1:0]                 m_r_data_valid_o,
    input  logic [NUM_MASTERS-1:0]                 m_r_data_ready_i,
    output logic [NUM_MASTERS*RW_DATA_WIDTH-1:0]   m_data_read_o,
    output logic                                   s_r_valid_o,
    input  logic                                   s_r_ready_i,
    output logic [RW_ADDR_WIDTH-1:0]               s_r_addr_o,
    output logic [SIZE_WIDTH-1:0]                  s_r_size_o,
    input  logic                                   s_r_data_valid_i,
    output logic                                   s_r_data_ready_o,
    input  logic [RW_DATA_WIDTH-1:0]               s_data_read_i,
    output logic [IDX_W-1:0]                       grant_o,
    output logic                                   busy_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [IDX_W-1:0]         r_grant;
    logic [IDX_W-1:0]         w_winner;
    logic [IDX_W-1:0]         w_lo_idx;
    logic [NUM_MASTERS-1:0]   w_gnt_oh;
    logic                     w_any_req;
    logic                     w_gnt_valid;
    logic                     w_gnt_data_ready;
    logic                     w_addr_hs;
    logic                     w_data_hs;
    logic [RW_ADDR_WIDTH-1:0] w_gnt_addr;
    logic [SIZE_WIDTH-1:0]    w_gnt_size;

    // One-hot view of the owner so every per-master mux is a simple AND/OR.
    always_comb begin
        w_gnt_oh = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            w_gnt_oh[i] = (r_grant == IDX_W'(i));
        end
    end

    always_comb begin
        w_gnt_addr = '0;
        w_gnt_size = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (w_gnt_oh[i]) begin
                w_gnt_addr = m_r_addr_i[i*RW_ADDR_WIDTH +: RW_ADDR_WIDTH];
                w_gnt_size = m_r_size_i[i*SIZE_WIDTH +: SIZE_WIDTH];
            end
        end
    end

    assign w_any_req        = |m_r_valid_i;
    assign w_gnt_valid      = |(m_r_valid_i & w_gnt_oh);
    assign w_gnt_data_ready = |(m_r_data_ready_i & w_gnt_oh);
    assign w_addr_hs        = (r_state == ST_ADDR) && w_gnt_valid && s_r_ready_i;
    assign w_data_hs        = (r_state == ST_DATA) && s_r_data_valid_i && w_gnt_data_ready;

`ifdef YSYX_22041207_ARB_RR_EN
    logic [IDX_W-1:0] r_rr_ptr;
    logic [IDX_W-1:0] w_hi_idx;
    logic             w_hi_hit;

    // Lowest requester at or above the pointer wins; otherwise wrap to the lowest requester overall.
    always_comb begin
        w_lo_idx = '0;
        w_hi_idx = '0;
        w_hi_hit = 1'b0;
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            if (m_r_valid_i[i]) begin
                w_lo_idx = IDX_W'(i);
                if (IDX_W'(i) >= r_rr_ptr) begin
                    w_hi_idx = IDX_W'(i);
                    w_hi_hit = 1'b1;
                end
            end
        end
        w_winner = w_hi_hit ? w_hi_idx : w_lo_idx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr <= '0;
        end else if (w_data_hs) begin
            r_rr_ptr <= (r_grant == IDX_W'(NUM_MASTERS - 1)) ? '0 : r_grant + IDX_W'(1);
        end
    end
`else
    always_comb begin
        w_lo_idx = '0;
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            if (m_r_valid_i[i]) begin
                w_lo_idx = IDX_W'(i);
            end
        end
        w_winner = w_lo_idx;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_IDLE && w_any_req) begin
                r_grant <= w_winner;
            end
        end
    end

    // A requester withdrawing before its address handshake aborts back to IDLE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_any_req) w_state_nxt = ST_ADDR;
            ST_ADDR: begin
                if (w_addr_hs)         w_state_nxt = ST_DATA;
                else if (!w_gnt_valid) w_state_nxt = ST_IDLE;
            end
            ST_DATA: if (w_data_hs) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        m_r_ready_o      = '0;
        m_r_data_valid_o = '0;
        m_data_read_o    = '0;
        s_r_valid_o      = 1'b0;
        s_r_addr_o       = '0;
        s_r_size_o       = '0;
        s_r_data_ready_o = 1'b0;
        case (r_state)
            ST_ADDR: begin
                s_r_valid_o = w_gnt_valid;
                s_r_addr_o  = w_gnt_addr;
                s_r_size_o  = w_gnt_size;
                m_r_ready_o = s_r_ready_i ? w_gnt_oh : '0;
            end
            ST_DATA: begin
                s_r_data_ready_o = w_gnt_data_ready;
                m_r_data_valid_o = s_r_data_valid_i ? w_gnt_oh : '0;
                for (int i = 0; i < NUM_MASTERS; i++) begin
                    if (w_gnt_oh[i]) begin
                        m_data_read_o[i*RW_DATA_WIDTH +: RW_DATA_WIDTH] = s_data_read_i;
                    end
                end
            end
            default: ;
        endcase
    end

    assign grant_o = r_grant;
    assign busy_o  = (r_state != ST_IDLE);

endmodule

// File: tb/tb_ysyx_22041207_axi_read_arbiter.sv
// Bench for the AXI read arbiter: directed scenarios plus a randomized run against a transaction-rule model.
module tb_ysyx_22041207_axi_read_arbiter;
    localparam int N  = 3;
    localparam int DW = 64;
    localparam int AW = 64;
    localparam int SW = 8;
    localparam int IW = $clog2(N);
`ifdef YSYX_22041207_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic [N-1:0]    m_r_valid_i, m_r_ready_o, m_r_data_valid_o, m_r_data_ready_i;
    logic [N*AW-1:0] m_r_addr_i;
    logic [N*SW-1:0] m_r_size_i;
    logic [N*DW-1:0] m_data_read_o;
    logic            s_r_valid_o, s_r_ready_i, s_r_data_valid_i, s_r_data_ready_o, busy_o;
    logic [AW-1:0]   s_r_addr_o;
    logic [SW-1:0]   s_r_size_o;
    logic [DW-1:0]   s_data_read_i;
    logic [IW-1:0]   grant_o;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    ysyx_22041207_axi_read_arbiter #(
        .NUM_MASTERS(N), .RW_DATA_WIDTH(DW), .RW_ADDR_WIDTH(AW), .SIZE_WIDTH(SW)
    ) dut (
        .clk(clk), .rst(rst),
        .m_r_valid_i(m_r_valid_i), .m_r_ready_o(m_r_ready_o),
        .m_r_addr_i(m_r_addr_i), .m_r_size_i(m_r_size_i),
        .m_r_data_valid_o(m_r_data_valid_o), .m_r_data_ready_i(m_r_data_ready_i),
        .m_data_read_o(m_data_read_o),
        .s_r_valid_o(s_r_valid_o), .s_r_ready_i(s_r_ready_i),
        .s_r_addr_o(s_r_addr_o), .s_r_size_o(s_r_size_o),
        .s_r_data_valid_i(s_r_data_valid_i), .s_r_data_ready_o(s_r_data_ready_o),
        .s_data_read_i(s_data_read_i),
        .grant_o(grant_o), .busy_o(busy_o)
    );

    // Reference arbitration: first requester found scanning from ptr upward, modulo N.
    function automatic int pick(input logic [N-1:0] v, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic int next_ptr(input int g);
        return RR ? (g + 1) % N : 0;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        m_r_valid_i      = '0;
        m_r_data_ready_i = '0;
        m_r_addr_i       = '0;
        m_r_size_i       = '0;
        s_r_ready_i      = 1'b0;
        s_r_data_valid_i = 1'b0;
        s_data_read_i    = '0;
    endtask

    task automatic do_reset;
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Always-ready slave; records which master completes each address handshake.
    task automatic serve(input int n, input bit keep, output int order[6], output int got);
        logic [N-1:0] hs;
        got = 0;
        for (int k = 0; k < 6; k++) order[k] = -1;
        for (int cyc = 0; cyc < 100 * n && got < n; cyc++) begin
            @(negedge clk);
            hs = m_r_ready_o & m_r_valid_i & {N{s_r_ready_i}};
            for (int i = 0; i < N; i++) begin
                if (hs[i] && got < 6) begin
                    order[got] = i;
                    got++;
                end
            end
            tick();
            if (!keep) m_r_valid_i = m_r_valid_i & ~hs;
        end
        m_r_valid_i = '0;
        for (int cyc = 0; cyc < 20 && busy_o; cyc++) tick();
    endtask

    task automatic test_reset;
        idle_inputs();
        m_r_valid_i      = '1;
        s_r_ready_i      = 1'b1;
        s_r_data_valid_i = 1'b1;
        m_r_data_ready_i = '1;
        rst = 1'b1;
        tick();
        tick();
        @(negedge clk);
        n_checks++; if (busy_o !== 1'b0) $display("FAIL reset_busy got %0h exp 0", busy_o); else n_pass++;
        n_checks++; if (grant_o !== '0) $display("FAIL reset_grant got %0h exp 0", grant_o); else n_pass++;
        n_checks++; if ({m_r_ready_o, m_r_data_valid_o, s_r_valid_o, s_r_data_ready_o} !== '0)
            $display("FAIL reset_handshakes got %0h exp 0", {m_r_ready_o, m_r_data_valid_o, s_r_valid_o, s_r_data_ready_o}); else n_pass++;
        n_checks++; if ({m_data_read_o, s_r_addr_o, s_r_size_o} !== '0)
            $display("FAIL reset_buses got %0h exp 0", {m_data_read_o, s_r_addr_o, s_r_size_o}); else n_pass++;
        idle_inputs();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_single;
        logic [N*DW-1:0] exp_d;
        idle_inputs();
        m_r_valid_i = 3'b010;
        m_r_addr_i[AW +: AW] = 64'h8000_0000;
        m_r_size_i[SW +: SW] = 8'd8;
        @(negedge clk);
        n_checks++; if (busy_o !== 1'b0) $display("FAIL single_arb_latency busy got %0h exp 0", busy_o); else n_pass++;
        tick();
        @(negedge clk);
        n_checks++; if ({s_r_valid_o, s_r_addr_o, s_r_size_o, grant_o, m_r_ready_o} !== {1'b1, 64'h8000_0000, 8'd8, 2'd1, 3'b000})
            $display("FAIL single_addr got %0h exp %0h", {s_r_valid_o, s_r_addr_o, s_r_size_o, grant_o, m_r_ready_o},
                     {1'b1, 64'h8000_0000, 8'd8, 2'd1, 3'b000}); else n_pass++;
        tick();
        s_r_ready_i = 1'b1;
        @(negedge clk);
        n_checks++; if (m_r_ready_o !== 3'b010) $display("FAIL single_ready got %b exp 010", m_r_ready_o); else n_pass++;
        tick();
        s_r_ready_i      = 1'b0;
        m_r_valid_i      = '0;
        s_r_data_valid_i = 1'b1;
        s_data_read_i    = 64'hDEAD_BEEF;
        m_r_data_ready_i = 3'b010;
        exp_d = '0;
        exp_d[DW +: DW] = 64'hDEAD_BEEF;
        @(negedge clk);
        n_checks++; if ({m_r_data_valid_o, s_r_data_ready_o, m_r_ready_o, s_r_valid_o} !== {3'b010, 1'b1, 3'b000, 1'b0})
            $display("FAIL single_data_ctl got %b exp 0101_0000", {m_r_data_valid_o, s_r_data_ready_o, m_r_ready_o, s_r_valid_o}); else n_pass++;
        n_checks++; if (m_data_read_o !== exp_d) $display("FAIL single_data got %0h exp %0h", m_data_read_o, exp_d); else n_pass++;
        tick();
        @(negedge clk);
        n_checks++; if ({busy_o, m_r_data_valid_o, s_r_data_ready_o} !== '0)
            $display("FAIL single_done got %b exp 0", {busy_o, m_r_data_valid_o, s_r_data_ready_o}); else n_pass++;
        idle_inputs();
    endtask

    task automatic test_priority;
        int ord[6];
        int got, ptr, e0, e1;
        do_reset();
        s_r_ready_i = 1'b1; s_r_data_valid_i = 1'b1; m_r_data_ready_i = '1;
        m_r_valid_i = 3'b011;
        ptr = 0;
        e0  = pick(3'b011, ptr);
        ptr = next_ptr(e0);
        e1  = pick(3'b011 & ~(3'b001 << e0), ptr);
        serve(2, 1'b0, ord, got);
        n_checks++; if (got !== 2) $display("FAIL prio_count got %0d exp 2", got); else n_pass++;
        n_checks++; if (ord[0] !== e0) $display("FAIL prio_first got %0d exp %0d", ord[0], e0); else n_pass++;
        n_checks++; if (ord[1] !== e1) $display("FAIL prio_second got %0d exp %0d", ord[1], e1); else n_pass++;
        idle_inputs();
    endtask

    task automatic test_rr_order;
        int ord[6];
        int got, ptr, e;
        do_reset();
        s_r_ready_i = 1'b1; s_r_data_valid_i = 1'b1; m_r_data_ready_i = '1;
        m_r_valid_i = '1;
        serve(6, 1'b1, ord, got);
        n_checks++; if (got !== 6) $display("FAIL order_count got %0d exp 6", got); else n_pass++;
        ptr = 0;
        for (int t = 0; t < 6; t++) begin
            e = pick('1, ptr);
            ptr = next_ptr(e);
            n_checks++; if (ord[t] !== e) $display("FAIL order_%0d got %0d exp %0d", t, ord[t], e); else n_pass++;
        end
        idle_inputs();
    endtask

    task automatic test_stall;
        logic [N*DW-1:0] exp_d;
        bit ok;
        idle_inputs();
        m_r_valid_i = 3'b001; s_r_ready_i = 1'b1; s_r_data_valid_i = 1'b1;
        s_data_read_i = {$urandom, $urandom};
        exp_d = '0;
        exp_d[0 +: DW] = s_data_read_i;
        ok = 1'b0;
        for (int c = 0; c < 20 && !ok; c++) begin
            @(negedge clk);
            if (m_r_ready_o[0]) ok = 1'b1;
            tick();
        end
        n_checks++; if (!ok) $display("FAIL stall_addr_hs got none exp handshake"); else n_pass++;
        m_r_valid_i = '0;
        s_r_ready_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_checks++; if ({busy_o, s_r_data_ready_o, m_r_data_valid_o} !== {1'b1, 1'b0, 3'b001})
                $display("FAIL stall_hold_%0d got %b exp 10001", k, {busy_o, s_r_data_ready_o, m_r_data_valid_o}); else n_pass++;
            tick();
        end
        m_r_data_ready_i = 3'b001;
        @(negedge clk);
        n_checks++; if ({s_r_data_ready_o, m_data_read_o} !== {1'b1, exp_d})
            $display("FAIL stall_release got %0h exp %0h", {s_r_data_ready_o, m_data_read_o}, {1'b1, exp_d}); else n_pass++;
        tick();
        @(negedge clk);
        n_checks++; if (busy_o !== 1'b0) $display("FAIL stall_done busy got %0h exp 0", busy_o); else n_pass++;
        idle_inputs();
    endtask

    task automatic test_reset_mid;
        int ord[6];
        int got;
        bit ok;
        idle_inputs();
        m_r_valid_i = 3'b100; s_r_ready_i = 1'b1; s_r_data_valid_i = 1'b1;
        s_data_read_i = {$urandom, $urandom};
        ok = 1'b0;
        for (int c = 0; c < 20 && !ok; c++) begin
            @(negedge clk);
            if (m_r_ready_o[2]) ok = 1'b1;
            tick();
        end
        m_r_valid_i = '0;
        @(negedge clk);
        n_checks++; if (!ok || m_r_data_valid_o !== 3'b100)
            $display("FAIL rstmid_in_data got %b exp 100", m_r_data_valid_o); else n_pass++;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_r_data_ready_i = '1;
        @(negedge clk);
        n_checks++; if ({busy_o, grant_o, m_r_data_valid_o, s_r_data_ready_o, m_r_ready_o, s_r_valid_o} !== '0)
            $display("FAIL rstmid_idle got %b exp 0", {busy_o, grant_o, m_r_data_valid_o, s_r_data_ready_o, m_r_ready_o, s_r_valid_o}); else n_pass++;
        n_checks++; if (m_data_read_o !== '0) $display("FAIL rstmid_data got %0h exp 0", m_data_read_o); else n_pass++;
        m_r_valid_i = 3'b010;
        serve(1, 1'b0, ord, got);
        n_checks++; if (got !== 1 || ord[0] !== 1) $display("FAIL rstmid_after got %0d/%0d exp 1/1", got, ord[0]); else n_pass++;
        idle_inputs();
    endtask

    // Cycle-level model: phase 0 idle, 1 address, 2 data; owner and pointer follow the arbitration rules.
    task automatic test_random;
        int ph, g, ptr;
        logic [N-1:0] drop, oh, exp_ready, exp_dv;
        logic exp_sv, exp_sdr;
        logic [AW-1:0] exp_addr;
        logic [SW-1:0] exp_size;
        logic [N*DW-1:0] exp_d;
        do_reset();
        ph = 0; g = 0; ptr = 0; drop = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            m_r_valid_i = m_r_valid_i & ~drop;
            for (int i = 0; i < N; i++) begin
                if (!m_r_valid_i[i]) begin
                    if ($urandom_range(2) == 0) begin
                        m_r_valid_i[i] = 1'b1;
                        m_r_addr_i[i*AW +: AW] = {$urandom, $urandom};
                        m_r_size_i[i*SW +: SW] = SW'($urandom);
                    end
                end else if ($urandom_range(15) == 0) begin
                    m_r_valid_i[i] = 1'b0;
                end
            end
            s_r_ready_i      = 1'($urandom_range(1));
            s_r_data_valid_i = 1'($urandom_range(1));
            s_data_read_i    = {$urandom, $urandom};
            m_r_data_ready_i = N'($urandom);
            @(negedge clk);
            oh = '0; oh[g] = 1'b1;
            exp_ready = (ph == 1 && s_r_ready_i) ? oh : '0;
            exp_sv    = (ph == 1) ? m_r_valid_i[g] : 1'b0;
            exp_addr  = (ph == 1) ? m_r_addr_i[g*AW +: AW] : '0;
            exp_size  = (ph == 1) ? m_r_size_i[g*SW +: SW] : '0;
            exp_dv    = (ph == 2 && s_r_data_valid_i) ? oh : '0;
            exp_sdr   = (ph == 2) ? m_r_data_ready_i[g] : 1'b0;
            exp_d     = '0;
            if (ph == 2) exp_d[g*DW +: DW] = s_data_read_i;
            n_checks++; if ({m_r_ready_o, s_r_valid_o, s_r_addr_o, s_r_size_o} !== {exp_ready, exp_sv, exp_addr, exp_size})
                $display("FAIL rand_addr c%0d got %0h exp %0h", cyc, {m_r_ready_o, s_r_valid_o, s_r_addr_o, s_r_size_o},
                         {exp_ready, exp_sv, exp_addr, exp_size}); else n_pass++;
            n_checks++; if ({m_r_data_valid_o, s_r_data_ready_o, m_data_read_o} !== {exp_dv, exp_sdr, exp_d})
                $display("FAIL rand_data c%0d got %0h exp %0h", cyc, {m_r_data_valid_o, s_r_data_ready_o, m_data_read_o},
                         {exp_dv, exp_sdr, exp_d}); else n_pass++;
            n_checks++; if ({busy_o, grant_o} !== {ph != 0, IW'(g)})
                $display("FAIL rand_status c%0d got %0h exp %0h", cyc, {busy_o, grant_o}, {ph != 0, IW'(g)}); else n_pass++;
            drop = '0;
            case (ph)
                0: if (|m_r_valid_i) begin g = pick(m_r_valid_i, ptr); ph = 1; end
                1: if (m_r_valid_i[g] && s_r_ready_i) begin ph = 2; drop[g] = 1'b1; end
                   else if (!m_r_valid_i[g]) ph = 0;
                default: if (s_r_data_valid_i && m_r_data_ready_i[g]) begin ph = 0; ptr = next_ptr(g); end
            endcase
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_single();
        test_priority();
        test_rr_order();
        test_stall();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
